// File: rtl/rob_multi_port_buffer.sv
// Reorder-buffer storage: in-order allocate/commit ring with out-of-order
// completion through p_num_wr tag-addressed write ports.
module rob_multi_port_buffer #(
  parameter int p_depth    = 32,
  parameter int p_ptrwidth = $clog2(p_depth),
  parameter int p_bitwidth = 32,
  parameter int p_num_wr   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 alloc_val,
  output logic                                 alloc_rdy,
  output logic [p_ptrwidth-1:0]                alloc_tag,
  input  logic [p_num_wr-1:0]                  wr_val,
  input  logic [p_num_wr-1:0][p_ptrwidth-1:0]  wr_tag,
  input  logic [p_num_wr-1:0][p_bitwidth-1:0]  wr_data,
  output logic                                 commit_val,
  input  logic                                 commit_rdy,
  output logic [p_ptrwidth-1:0]                commit_tag,
  output logic [p_bitwidth-1:0]                commit_data,
  output logic [p_depth-1:0]                   occ,
  output logic [p_depth-1:0]                   done,
  output logic [p_ptrwidth:0]                  count,
  output logic                                 wr_err
);

  localparam logic [p_ptrwidth:0] PTR_ONE = {{p_ptrwidth{1'b0}}, 1'b1};

  logic [p_ptrwidth:0]                 head;
  logic [p_ptrwidth:0]                 tail;
  logic [p_depth-1:0][p_bitwidth-1:0]  payload;
  logic [p_depth-1:0][p_bitwidth-1:0]  payload_nxt;
  logic [p_depth-1:0]                  occ_nxt;
  logic [p_depth-1:0]                  done_nxt;
  logic [p_ptrwidth-1:0]               head_idx;
  logic [p_ptrwidth-1:0]               tail_idx;
  logic                                full;
  logic                                alloc_fire;
  logic                                commit_fire;
  logic                                err_set;

  assign head_idx    = head[p_ptrwidth-1:0];
  assign tail_idx    = tail[p_ptrwidth-1:0];
  assign full        = (head_idx == tail_idx) && (head[p_ptrwidth] != tail[p_ptrwidth]);
  assign alloc_rdy   = !full;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_val && !full;
  assign commit_val  = occ[head_idx] && done[head_idx];
  assign commit_tag  = head_idx;
  assign commit_data = payload[head_idx];
  assign commit_fire = commit_val && commit_rdy;
  assign count       = tail - head;

  // Later ports overwrite earlier ones, so the highest-index port wins a tag
  // collision. A write racing the commit of its own entry is silently dropped.
  always_comb begin
    payload_nxt = payload;
    done_nxt    = done;
    occ_nxt     = occ;
    err_set     = 1'b0;
    for (int unsigned k = 0; k < p_num_wr; k++) begin
      if (wr_val[k]) begin
        if (!occ[wr_tag[k]]) begin
          err_set = 1'b1;
        end else if (!(commit_fire && (wr_tag[k] == head_idx))) begin
          payload_nxt[wr_tag[k]] = wr_data[k];
          done_nxt[wr_tag[k]]    = 1'b1;
        end
      end
    end
    if (alloc_fire) begin
      occ_nxt[tail_idx]  = 1'b1;
      done_nxt[tail_idx] = 1'b0;
    end
    if (commit_fire) begin
      occ_nxt[head_idx]  = 1'b0;
      done_nxt[head_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      done    <= '0;
      payload <= '0;
      wr_err  <= 1'b0;
    end else if (flush) begin
      // wr_err deliberately survives a flush
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      done    <= '0;
      payload <= '0;
    end else begin
      if (alloc_fire)  tail <= tail + PTR_ONE;
      if (commit_fire) head <= head + PTR_ONE;
      if (err_set)     wr_err <= 1'b1;
      occ     <= occ_nxt;
      done    <= done_nxt;
      payload <= payload_nxt;
    end
  end

endmodule

// File: tb/tb_rob_multi_port_buffer.sv
// Directed vector table, full/wrap and async-reset sequences, and a randomised
// scoreboard run for rob_multi_port_buffer.
module tb_rob_multi_port_buffer;
  localparam int D  = 32;
  localparam int PW = 5;
  localparam int BW = 32;
  localparam int NW = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   flush = 1'b0;
  logic                   alloc_val = 1'b0;
  logic                   alloc_rdy;
  logic [PW-1:0]          alloc_tag;
  logic [NW-1:0]          wr_val = '0;
  logic [NW-1:0][PW-1:0]  wr_tag = '0;
  logic [NW-1:0][BW-1:0]  wr_data = '0;
  logic                   commit_val;
  logic                   commit_rdy = 1'b0;
  logic [PW-1:0]          commit_tag;
  logic [BW-1:0]          commit_data;
  logic [D-1:0]           occ;
  logic [D-1:0]           done;
  logic [PW:0]            count;
  logic                   wr_err;

  int checks = 0;
  int failures = 0;

  rob_multi_port_buffer #(.p_depth(D), .p_ptrwidth(PW), .p_bitwidth(BW), .p_num_wr(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_tag(alloc_tag),
    .wr_val(wr_val), .wr_tag(wr_tag), .wr_data(wr_data),
    .commit_val(commit_val), .commit_rdy(commit_rdy), .commit_tag(commit_tag),
    .commit_data(commit_data), .occ(occ), .done(done), .count(count), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, av;
    logic [1:0]  wv;
    logic [4:0]  t0, t1;
    logic [31:0] d0, d1;
    logic        cr;
    logic        e_ar;
    logic [4:0]  e_at;
    logic        e_cv;
    logic [4:0]  e_ct;
    logic [31:0] e_cd;
    logic [5:0]  e_cnt;
    logic [31:0] e_occ, e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic fl, logic av, logic [1:0] wv, logic [4:0] t0, logic [31:0] d0,
                              logic [4:0] t1, logic [31:0] d1, logic cr, logic ar, logic [4:0] at,
                              logic cv, logic [4:0] ct, logic [31:0] cd, logic [5:0] cnt,
                              logic [31:0] o, logic [31:0] dn, logic err);
    vec_t v;
    v.fl = fl; v.av = av; v.wv = wv; v.t0 = t0; v.d0 = d0; v.t1 = t1; v.d1 = d1; v.cr = cr;
    v.e_ar = ar; v.e_at = at; v.e_cv = cv; v.e_ct = ct; v.e_cd = cd; v.e_cnt = cnt;
    v.e_occ = o; v.e_done = dn; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; alloc_val = 1'b0; wr_val = '0; commit_rdy = 1'b0;
  endtask

  // scoreboard model state
  bit          m_occ[D];
  bit          m_done[D];
  logic [31:0] m_pay[D];
  int          m_head, m_tail;
  bit          m_err;
  int          q[$];

  initial begin
    // async reset visible before any clock edge
    #2;
    chk("rst_alloc_rdy", 64'(alloc_rdy), 64'd1);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("rst_commit_val", 64'(commit_val), 64'd0);
    chk("rst_commit_data", 64'(commit_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wr_err", 64'(wr_err), 64'd0);
    rst = 1'b1;

    tbl[0]  = mk(0,1,2'b00,0,0,0,0,0, 1,1,0,0,0,1,32'h1,32'h0,0);
    tbl[1]  = mk(0,1,2'b00,0,0,0,0,0, 1,2,0,0,0,2,32'h3,32'h0,0);
    tbl[2]  = mk(0,1,2'b00,0,0,0,0,0, 1,3,0,0,0,3,32'h7,32'h0,0);
    tbl[3]  = mk(0,1,2'b00,0,0,0,0,0, 1,4,0,0,0,4,32'hF,32'h0,0);
    tbl[4]  = mk(0,0,2'b01,2,32'hC,0,0,0, 1,4,0,0,0,4,32'hF,32'h4,0);
    tbl[5]  = mk(0,0,2'b01,0,32'hA,0,0,0, 1,4,1,0,32'hA,4,32'hF,32'h5,0);
    tbl[6]  = mk(0,0,2'b01,1,32'hB,0,0,1, 1,4,1,1,32'hB,3,32'hE,32'h6,0);
    tbl[7]  = mk(0,0,2'b00,0,0,0,0,1, 1,4,1,2,32'hC,2,32'hC,32'h4,0);
    tbl[8]  = mk(0,0,2'b00,0,0,0,0,1, 1,4,0,3,0,1,32'h8,32'h0,0);
    tbl[9]  = mk(0,0,2'b00,0,0,0,0,1, 1,4,0,3,0,1,32'h8,32'h0,0);
    tbl[10] = mk(0,1,2'b00,0,0,0,0,0, 1,5,0,3,0,2,32'h18,32'h0,0);
    tbl[11] = mk(0,1,2'b00,0,0,0,0,0, 1,6,0,3,0,3,32'h38,32'h0,0);
    tbl[12] = mk(0,0,2'b11,5,32'h11,5,32'h22,0, 1,6,0,3,0,3,32'h38,32'h20,0);
    tbl[13] = mk(0,0,2'b01,3,32'h33,0,0,0, 1,6,1,3,32'h33,3,32'h38,32'h28,0);
    tbl[14] = mk(0,0,2'b00,0,0,0,0,1, 1,6,0,4,0,2,32'h30,32'h20,0);
    tbl[15] = mk(0,0,2'b10,0,0,4,32'h44,1, 1,6,1,4,32'h44,2,32'h30,32'h30,0);
    tbl[16] = mk(0,0,2'b00,0,0,0,0,1, 1,6,1,5,32'h22,1,32'h20,32'h20,0);
    tbl[17] = mk(0,0,2'b01,5,32'h55,0,0,1, 1,6,0,6,0,0,32'h0,32'h0,0);
    tbl[18] = mk(0,0,2'b01,9,32'h99,0,0,0, 1,6,0,6,0,0,32'h0,32'h0,1);
    tbl[19] = mk(0,1,2'b00,0,0,0,0,0, 1,7,0,6,0,1,32'h40,32'h0,1);
    tbl[20] = mk(0,0,2'b01,6,32'h66,0,0,0, 1,7,1,6,32'h66,1,32'h40,32'h40,1);
    tbl[21] = mk(1,1,2'b10,0,0,6,32'h77,1, 1,0,0,0,0,0,32'h0,32'h0,1);
    tbl[22] = mk(0,1,2'b00,0,0,0,0,0, 1,1,0,0,0,1,32'h1,32'h0,1);
    tbl[23] = mk(0,0,2'b01,0,32'hAB,0,0,0, 1,1,1,0,32'hAB,1,32'h1,32'h1,1);
    tbl[24] = mk(0,1,2'b00,0,0,0,0,1, 1,2,0,1,0,1,32'h2,32'h0,1);

    for (int i = 0; i < 25; i++) begin
      flush = tbl[i].fl; alloc_val = tbl[i].av; wr_val = tbl[i].wv;
      wr_tag[0] = tbl[i].t0; wr_tag[1] = tbl[i].t1;
      wr_data[0] = tbl[i].d0; wr_data[1] = tbl[i].d1; commit_rdy = tbl[i].cr;
      step();
      chk($sformatf("v%0d_alloc_rdy", i), 64'(alloc_rdy), 64'(tbl[i].e_ar));
      chk($sformatf("v%0d_alloc_tag", i), 64'(alloc_tag), 64'(tbl[i].e_at));
      chk($sformatf("v%0d_commit_val", i), 64'(commit_val), 64'(tbl[i].e_cv));
      chk($sformatf("v%0d_commit_tag", i), 64'(commit_tag), 64'(tbl[i].e_ct));
      chk($sformatf("v%0d_commit_data", i), 64'(commit_data), 64'(tbl[i].e_cd));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d_occ", i), 64'(occ), 64'(tbl[i].e_occ));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(tbl[i].e_done));
      chk($sformatf("v%0d_wr_err", i), 64'(wr_err), 64'(tbl[i].e_err));
    end

    // fill, full-boundary alloc/commit, then three full wraps
    idle_inputs(); flush = 1'b1; step(); flush = 1'b0;
    alloc_val = 1'b1;
    for (int i = 0; i < D; i++) step();
    chk("full_alloc_rdy", 64'(alloc_rdy), 64'd0);
    chk("full_count", 64'(count), 64'd32);
    chk("full_occ", 64'(occ), 64'hFFFF_FFFF);
    step();
    chk("full_ignored_count", 64'(count), 64'd32);
    chk("full_ignored_tag", 64'(alloc_tag), 64'd0);
    alloc_val = 1'b0; wr_val = 2'b01; wr_tag[0] = 0; wr_data[0] = 32'h1000;
    step();
    chk("full_head_ready", 64'(commit_val), 64'd1);
    wr_val = '0; commit_rdy = 1'b1; alloc_val = 1'b1;
    step();
    chk("full_commit_count", 64'(count), 64'd31);
    chk("full_commit_rdy", 64'(alloc_rdy), 64'd1);
    chk("full_commit_tag", 64'(alloc_tag), 64'd0);
    commit_rdy = 1'b0;
    step();
    chk("wrap_alloc_count", 64'(count), 64'd32);
    chk("wrap_alloc_tag", 64'(alloc_tag), 64'd1);
    alloc_val = 1'b0;
    begin
      int h;
      h = 1;
      for (int i = 0; i < 3 * D; i++) begin
        wr_val = 2'b01; wr_tag[0] = PW'(h); wr_data[0] = 32'h2000 + 32'(i);
        step();
        wr_val = '0;
        chk("wrap_cv", 64'(commit_val), 64'd1);
        chk("wrap_tag", 64'(commit_tag), 64'(h));
        chk("wrap_data", 64'(commit_data), 64'(32'h2000 + 32'(i)));
        commit_rdy = 1'b1; step(); commit_rdy = 1'b0;
        alloc_val = 1'b1; step(); alloc_val = 1'b0;
        chk("wrap_count", 64'(count), 64'd32);
        h = (h + 1) % D;
      end
    end

    // asynchronous reset in the middle of a cycle with traffic active
    alloc_val = 1'b1; commit_rdy = 1'b1; wr_val = 2'b11;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_occ", 64'(occ), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("arst_commit_val", 64'(commit_val), 64'd0);
    chk("arst_wr_err", 64'(wr_err), 64'd0);
    idle_inputs();
    #2 rst = 1'b1;

    // randomised traffic against a scoreboard
    for (int i = 0; i < D; i++) begin m_occ[i] = 0; m_done[i] = 0; m_pay[i] = '0; end
    m_head = 0; m_tail = 0; m_err = 0;
    for (int c = 0; c < 400; c++) begin
      int cnt, h, t;
      bit af, cf;
      bit nw[D];
      logic [31:0] nd[D];
      logic [31:0] mocc;
      @(negedge clk);
      cnt = (m_tail - m_head) & 63;
      h = m_head % D; t = m_tail % D;
      alloc_val = ($urandom % 3) != 0;
      commit_rdy = ($urandom % 2) == 1;
      for (int k = 0; k < NW; k++) begin
        wr_val[k] = ($urandom % 2) == 1;
        if (cnt > 0 && ($urandom % 16) != 0) wr_tag[k] = PW'((m_head + int'($urandom % cnt)) % D);
        else wr_tag[k] = PW'($urandom % D);
        wr_data[k] = $urandom;
      end
      af = alloc_val && (cnt != D);
      cf = m_occ[h] && m_done[h] && commit_rdy;
      if (cf) begin
        int et;
        et = q.pop_front();
        chk("sb_commit_tag", 64'(commit_tag), 64'(et));
        chk("sb_commit_data", 64'(commit_data), 64'(m_pay[h]));
      end
      for (int i = 0; i < D; i++) begin nw[i] = 0; nd[i] = '0; end
      for (int k = 0; k < NW; k++) begin
        if (wr_val[k]) begin
          if (!m_occ[wr_tag[k]]) m_err = 1;
          else if (!(cf && int'(wr_tag[k]) == h)) begin nw[wr_tag[k]] = 1; nd[wr_tag[k]] = wr_data[k]; end
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < D; i++) if (nw[i]) begin m_pay[i] = nd[i]; m_done[i] = 1; end
      if (af) begin m_occ[t] = 1; m_done[t] = 0; m_tail = (m_tail + 1) % 64; q.push_back(t); end
      if (cf) begin m_occ[h] = 0; m_done[h] = 0; m_head = (m_head + 1) % 64; end
      mocc = '0;
      for (int i = 0; i < D; i++) mocc[i] = m_occ[i];
      h = m_head % D;
      chk("sb_occ", 64'(occ), 64'(mocc));
      chk("sb_count", 64'(count), 64'((m_tail - m_head) & 63));
      chk("sb_commit_val", 64'(commit_val), 64'(m_occ[h] && m_done[h]));
      chk("sb_head_tag", 64'(commit_tag), 64'(h));
      chk("sb_wr_err", 64'(wr_err), 64'(m_err));
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_multi_port_buffer.md
Name: rob_multi_port_buffer

Overview:
Parametrised reorder-buffer storage: circular array of p_depth entries with internal allocate (tail) and commit (head) pointers, per-entry occupancy and done bits, and p_num_wr independent completion write ports addressed by tag. Entries are allocated in program order, completed out of order, and committed in order through a val/rdy handshake. It sits between dispatch (allocation), the execution units (completion) and retire logic (commit).

Parameters:
p_depth, 32, number of entries; must be a power of two, >= 2
p_ptrwidth, $clog2(p_depth), tag/index width
p_bitwidth, 32, payload width per entry
p_num_wr, 2, number of completion write ports, >= 1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
flush  input  1  synchronous clear of all entries and pointers
alloc_val  input  1  dispatch requests one entry
alloc_rdy  output  1  entry available (not full)
alloc_tag  output  p_ptrwidth  index that the next allocation receives (tail)
wr_val  input  [p_num_wr] x 1  completion write valid, per port
wr_tag  input  [p_num_wr] x p_ptrwidth  target entry, per port
wr_data  input  [p_num_wr] x p_bitwidth  completion payload, per port
commit_val  output  1  head entry allocated and done
commit_rdy  input  1  retire accepts head
commit_tag  output  p_ptrwidth  head index
commit_data  output  p_bitwidth  head payload
occ  output  p_depth  per-entry allocated bits
done  output  p_depth  per-entry completed bits
count  output  p_ptrwidth+1  number of allocated entries, 0..p_depth
wr_err  output  1  sticky: completion targeted an unallocated entry

Behaviour:
- Pointers: head and tail are p_ptrwidth+1 bits wide, and the MSB is the wrap bit. The buffer is empty when head==tail. It is full when the index bits are equal and the wrap bits differ. Indices wrap naturally from p_depth-1 to 0.
- Reset (rst=0, asynchronous): head=tail=0; occ=0; done=0; all payloads=0; wr_err=0. Resulting outputs: alloc_rdy=1, alloc_tag=0, commit_val=0, commit_tag=0, commit_data=0, count=0.
- Allocation: alloc_rdy = !full, computed from current state only. On alloc_val&&alloc_rdy, occ[tail] is set, done[tail] is cleared, and tail increments. The payload is not cleared. alloc_val while full is ignored with no state change.
- Completion: on wr_val[k] for an entry whose occ is set at the start of the cycle, payload[tag] <= wr_data[k] and done[tag] is set at the next edge. The data becomes visible one cycle after the write.
  - If several ports target the same tag in one cycle, the highest-index port wins.
  - A write to an entry already done overwrites its payload; done stays set.
  - A write to an entry whose occ is clear (including the entry being allocated this same cycle) is dropped, and wr_err is set. wr_err clears only on reset.
- Commit: commit_val = occ[head] && done[head]. commit_tag = head index. commit_data = payload[head]. All three are combinational from registers, so there is zero added latency. On commit_val&&commit_rdy, occ[head] and done[head] are cleared and head increments. commit_rdy without commit_val has no effect.
- Same-cycle commit and completion to the head tag: the committed data is the pre-write payload and the write is dropped. The entry is freed and wr_err is not set.
- Same-cycle alloc and commit: both take effect and count is unchanged. A full buffer cannot allocate in the same cycle as it commits.
- Count: count = tail - head (p_ptrwidth+1-bit subtraction), giving the full range 0..p_depth.
- Flush (synchronous, when rst=1): has priority over alloc, completion and commit that cycle. All of those are ignored, and the state returns to the reset values except wr_err, which is held.

Test Plan:
- Reset, then allocate 4 entries with commit_rdy=0 -> alloc_tag sequence 0,1,2,3; occ=0x0000000F; count=4; commit_val=0.
- Complete tags 2, 0, 1 with data 0xC, 0xA, 0xB, then hold commit_rdy=1 -> commits occur in order: tag 0/0xA, tag 1/0xB, tag 2/0xC; then commit_val=0 until tag 3 completes; count ends at 1.
- Fill all 32 entries -> alloc_rdy=0 and count=32. Complete and commit the head; in the same cycle assert alloc_val -> the allocation is not accepted that cycle and is accepted the next cycle with alloc_tag=0 (wrap). Run 3 full wraps and check ordering is preserved.
- Ports 0 and 1 both write tag 5 with 0x11 and 0x22 -> payload[5]=0x22; a write to unallocated tag 9 -> the entry is unchanged and wr_err=1, sticky through a flush.
- Assert flush with alloc_val, wr_val and commit_rdy active -> next cycle occ=0, done=0, count=0, alloc_tag=0 and no commit is observed. Deassert rst mid-traffic -> outputs are at reset values immediately, without waiting for a clock edge.
- Randomised alloc/complete/commit traffic against a scoreboard model -> every committed tag/data matches the model, and occ and count are consistent every cycle.
